// File: rtl/elevator_pkg.sv
// Shared types and request-scan helpers for the SCAN elevator controller.
package elevator_pkg;

   // Widest request vector the scan helpers accept; callers zero-extend.
   localparam int unsigned MAX_FLOORS = 64;

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;
   typedef enum logic {UP, DOWN} dir_t;

   // True when any request lies strictly above floor_idx.
   function automatic logic any_above(input logic [MAX_FLOORS-1:0] vec,
                                      input int unsigned floor_idx);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
         if (i > floor_idx && vec[i]) hit = 1'b1;
      end
      return hit;
   endfunction

   // True when any request lies strictly below floor_idx.
   function automatic logic any_below(input logic [MAX_FLOORS-1:0] vec,
                                      input int unsigned floor_idx);
      logic hit;
      hit = 1'b0;
      for (int unsigned i = 0; i < MAX_FLOORS; i++) begin
         if (i < floor_idx && vec[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/elevator_timer.sv
// Loadable down-counter that parks at zero; used for travel and door dwell.
module elevator_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         zero
);

   logic [W-1:0] count;

   // Load wins over counting; the counter holds once it reaches zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - W'(1);
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator car controller serving latched requests in SCAN order.
module elevator_scan_ctrl
   import elevator_pkg::*;
#(
   parameter int unsigned NUM_FLOORS  = 8,
   parameter int unsigned WEIGHT_W    = 8,
   parameter int unsigned MAX_WEIGHT  = 180,
   parameter int unsigned MOVE_CYCLES = 4,
   parameter int unsigned DOOR_CYCLES = 6,
   parameter int unsigned FLOOR_W     = $clog2(NUM_FLOORS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_FLOORS-1:0] floor_request,
   input  logic [WEIGHT_W-1:0]   weight,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic                  moving_up,
   output logic                  moving_down,
   output logic                  door_open,
   output logic                  overload,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int unsigned MT_W = $clog2(MOVE_CYCLES + 1);
   localparam int unsigned DT_W = $clog2(DOOR_CYCLES + 1);

   state_t                  state, state_nxt;
   dir_t                    dir, dir_nxt;
   logic [FLOOR_W-1:0]      floor_nxt, step_up, step_dn;
   logic [NUM_FLOORS-1:0]   clear_mask;
   logic                    move_load, door_load, move_zero, door_zero;
   logic                    above, below, above_step, below_step;

   // Neighbouring floors, clamped so the car never leaves the shaft.
   assign step_up = (current_floor == FLOOR_W'(NUM_FLOORS - 1)) ? current_floor
                                                                : current_floor + FLOOR_W'(1);
   assign step_dn = (current_floor == '0) ? current_floor : current_floor - FLOOR_W'(1);

   // Requests ahead of the car now, and ahead of the floor it is about to reach.
   assign above      = any_above(MAX_FLOORS'(pending), 32'(current_floor));
   assign below      = any_below(MAX_FLOORS'(pending), 32'(current_floor));
   assign above_step = any_above(MAX_FLOORS'(pending), 32'(step_up));
   assign below_step = any_below(MAX_FLOORS'(pending), 32'(step_dn));

   // Next state, direction, floor and timer loads.
   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      floor_nxt = current_floor;
      move_load = 1'b0;
      door_load = 1'b0;
      case (state)
         IDLE: begin
            if (pending[current_floor]) begin
               state_nxt = DOOR;
               door_load = 1'b1;
            end else if (!overload) begin
               if (dir == UP) begin
                  if (above) begin
                     state_nxt = MOVE_UP;
                     move_load = 1'b1;
                  end else if (below) begin
                     state_nxt = MOVE_DOWN;
                     dir_nxt   = DOWN;
                     move_load = 1'b1;
                  end
               end else begin
                  if (below) begin
                     state_nxt = MOVE_DOWN;
                     move_load = 1'b1;
                  end else if (above) begin
                     state_nxt = MOVE_UP;
                     dir_nxt   = UP;
                     move_load = 1'b1;
                  end
               end
            end
         end
         MOVE_UP: begin
            if (move_zero) begin
               floor_nxt = step_up;
               if (pending[step_up]) begin
                  state_nxt = DOOR;
                  door_load = 1'b1;
               end else if (above_step) begin
                  move_load = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         MOVE_DOWN: begin
            if (move_zero) begin
               floor_nxt = step_dn;
               if (pending[step_dn]) begin
                  state_nxt = DOOR;
                  door_load = 1'b1;
               end else if (below_step) begin
                  move_load = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         DOOR: begin
            if (floor_request[current_floor] || overload) begin
               door_load = 1'b1;
            end else if (door_zero) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The floor being served (or about to be) swallows its own request.
   always_comb begin
      clear_mask = '0;
      if (state == DOOR || state_nxt == DOOR) begin
         clear_mask = NUM_FLOORS'(1) << floor_nxt;
      end
   end

   // Car registers and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         dir           <= UP;
         current_floor <= '0;
         pending       <= '0;
         overload      <= 1'b0;
         moving_up     <= 1'b0;
         moving_down   <= 1'b0;
         door_open     <= 1'b0;
      end else begin
         state         <= state_nxt;
         dir           <= dir_nxt;
         current_floor <= floor_nxt;
         pending       <= (pending | floor_request) & ~clear_mask;
         overload      <= (weight > WEIGHT_W'(MAX_WEIGHT));
         moving_up     <= (state_nxt == MOVE_UP);
         moving_down   <= (state_nxt == MOVE_DOWN);
         door_open     <= (state_nxt == DOOR);
      end
   end

   elevator_timer #(.W(MT_W)) u_move_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (move_load),
      .load_val (MT_W'(MOVE_CYCLES - 1)),
      .zero     (move_zero)
   );

   elevator_timer #(.W(DT_W)) u_door_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (door_load),
      .load_val (DT_W'(DOOR_CYCLES - 1)),
      .zero     (door_zero)
   );

endmodule
